// File: rtl/pattern_serializer_if.sv
// Handshake and data bundle between a transmit controller
// and the pattern serializer.
interface pattern_serializer_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic [CNT_W-1:0] reps;
  logic [CNT_W-1:0] gap;
  logic             dataout;
  logic             valid;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, abort, pattern, pat_len, reps, gap,
    input  dataout, valid, busy, done, state
  );

  modport slave (
    input  start, abort, pattern, pat_len, reps, gap,
    output dataout, valid, busy, done, state
  );
endinterface

// File: rtl/pattern_serializer.sv
// Serial pattern transmitter: shifts a latched pattern out
// MSB-first a programmed number of times with idle gaps.
module pattern_serializer #(
  parameter int   PAT_W    = 8,
  parameter int   LEN_W    = 4,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_LVL = 1'b0
) (
  input logic clk,
  input logic rst,
  pattern_serializer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [CNT_W-1:0] rep_q;
  logic [CNT_W-1:0] gcfg_q;
  logic [CNT_W-1:0] gap_q;
  logic             dout_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [LEN_W-1:0] len_d;
  logic [CNT_W-1:0] reps_d;

  always_comb begin
    len_d  = bus.pat_len;
    reps_d = bus.reps;
    if (bus.pat_len == '0 || bus.pat_len > LEN_MAX)
      len_d = LEN_MAX;
    if (bus.reps == '0)
      reps_d = CNT_ONE;
  end

  function automatic logic bit_at(
    input logic [PAT_W-1:0] p,
    input logic [LEN_W-1:0] i
  );
    return |(p & (PAT_W'(1) << i));
  endfunction

  // idx_q is the index of the bit currently on dataout;
  // gap_q counts GAP cycles left including the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      gcfg_q  <= '0;
      gap_q   <= '0;
      dout_q  <= IDLE_LVL;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (state_q != IDLE && bus.abort) begin
      state_q <= IDLE;
      dout_q  <= IDLE_LVL;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start && !bus.abort) begin
            state_q <= SEND;
            pat_q   <= bus.pattern;
            len_q   <= len_d;
            idx_q   <= len_d - LEN_ONE;
            rep_q   <= reps_d;
            gcfg_q  <= bus.gap;
            dout_q  <= bit_at(bus.pattern, len_d - LEN_ONE);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          if (idx_q != '0) begin
            idx_q  <= idx_q - LEN_ONE;
            dout_q <= bit_at(pat_q, idx_q - LEN_ONE);
          end else if (rep_q > CNT_ONE) begin
            rep_q <= rep_q - CNT_ONE;
            if (gcfg_q != '0) begin
              state_q <= GAP;
              gap_q   <= gcfg_q;
              dout_q  <= IDLE_LVL;
              valid_q <= 1'b0;
            end else begin
              idx_q  <= len_q - LEN_ONE;
              dout_q <= bit_at(pat_q, len_q - LEN_ONE);
            end
          end else begin
            state_q <= DONE;
            dout_q  <= IDLE_LVL;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        GAP: begin
          if (gap_q > CNT_ONE) begin
            gap_q <= gap_q - CNT_ONE;
          end else begin
            state_q <= SEND;
            idx_q   <= len_q - LEN_ONE;
            dout_q  <= bit_at(pat_q, len_q - LEN_ONE);
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state   = state_q;
  assign bus.dataout = dout_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Randomised bench for pattern_serializer, checked against
// a per-cycle expected trace built from the transmit rules.
module tb_pattern_serializer;

  localparam logic IDLE = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pattern_serializer_if #(.PAT_W(8), .LEN_W(4), .CNT_W(4)) bus ();

  pattern_serializer #(
    .PAT_W(8), .LEN_W(4), .CNT_W(4), .IDLE_LVL(IDLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ev(
    input logic [1:0] s, input logic b,
    input logic v, input logic d, input logic o
  );
    return {s, b, v, d, o};
  endfunction

  function automatic logic [5:0] obs();
    return {bus.state, bus.busy, bus.valid,
            bus.done, bus.dataout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected trace, one entry per cycle after the start edge.
  task automatic run(
    input string      name,
    input logic [7:0] p,
    input logic [3:0] l,
    input logic [3:0] r,
    input logic [3:0] g,
    input int         abort_at,
    input bit         noise
  );
    logic [5:0] q[$];
    int L, R;
    L = (l == 0 || l > 8) ? 8 : int'(l);
    R = (r == 0) ? 1 : int'(r);
    for (int rep = 0; rep < R; rep++) begin
      for (int b = L - 1; b >= 0; b--)
        q.push_back(ev(2'd1, 1, 1, 0, p[b]));
      if (rep < R - 1)
        for (int k = 0; k < int'(g); k++)
          q.push_back(ev(2'd2, 1, 0, 0, IDLE));
    end
    q.push_back(ev(2'd3, 0, 0, 1, IDLE));
    if (abort_at >= 0 && abort_at < q.size())
      q = q[0:abort_at];
    q.push_back(ev(2'd0, 0, 0, 0, IDLE));

    bus.pattern = p;
    bus.pat_len = l;
    bus.reps    = r;
    bus.gap     = g;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < q.size(); j++) begin
      if (noise && j < q.size() - 1) begin
        bus.pattern = 8'($urandom);
        bus.pat_len = 4'($urandom);
        bus.reps    = 4'($urandom);
        bus.gap     = 4'($urandom);
        bus.start   = 1'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      check($sformatf("%s[%0d]", name, j), 32'(obs()), 32'(q[j]));
      if (j < q.size() - 1) begin
        if (j == abort_at) bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.pattern = '0;
    bus.pat_len = '0;
    bus.reps    = '0;
    bus.gap     = '0;
    tick();
    tick();
    check("reset", 32'(obs()), 32'(ev(2'd0, 0, 0, 0, IDLE)));
    #3 rst = 1'b0;
    tick();
    check("idle", 32'(obs()), 32'(ev(2'd0, 0, 0, 0, IDLE)));

    run("basic", 8'b1011_0110, 4'd8, 4'd1, 4'd0, -1, 0);
    run("short", 8'hAB, 4'd4, 4'd3, 4'd2, -1, 0);
    run("clamp", 8'b1011_0110, 4'd0, 4'd0, 4'd0, -1, 0);
    run("clamp9", 8'h5C, 4'd9, 4'd2, 4'd1, -1, 0);
    run("b2b", 8'hF6, 4'd4, 4'd2, 4'd0, -1, 1);
    run("abort", 8'hC3, 4'd8, 4'd2, 4'd1, 2, 0);
    run("fresh", 8'hC3, 4'd8, 4'd1, 4'd0, -1, 0);
    run("len1", 8'h01, 4'd1, 4'd3, 4'd1, -1, 0);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_start", 32'(obs()), 32'(ev(2'd0, 0, 0, 0, IDLE)));

    // Async reset raised between edges while in GAP.
    bus.pattern = 8'hA5;
    bus.pat_len = 4'd4;
    bus.reps    = 4'd3;
    bus.gap     = 4'd3;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("in_gap", 32'(obs()), 32'(ev(2'd2, 1, 0, 0, IDLE)));
    #3 rst = 1'b1;
    #1;
    check("async_rst", 32'(obs()), 32'(ev(2'd0, 0, 0, 0, IDLE)));
    #2 rst = 1'b0;
    tick();
    check("post_rst", 32'(obs()), 32'(ev(2'd0, 0, 0, 0, IDLE)));
    run("restart", 8'b1011_0110, 4'd8, 4'd1, 4'd0, -1, 0);

    for (int t = 0; t < 40; t++) begin
      logic [7:0] p;
      logic [3:0] l, r, g;
      int         ab;
      p  = 8'($urandom);
      l  = 4'($urandom);
      r  = 4'($urandom_range(0, 5));
      g  = 4'($urandom_range(0, 4));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      run($sformatf("rnd%0d", t), p, l, r, g, ab, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Serial pattern transmitter. It drives a bit stream, one bit per clock, into the serial data input of the pattern identifier. It loads a programmable bit pattern and shifts it out MSB-first a programmed number of times, with optional idle gaps between repetitions. A start/busy/done handshake lets a controller or bench sequence transmissions deterministically against the identifier's `hit` output.

## Interface
- `PAT_W`, 8, maximum pattern length in bits
- `LEN_W`, 4, width of `pat_len`; must satisfy 2^LEN_W > PAT_W
- `CNT_W`, 4, width of `reps` and `gap`
- `IDLE_LVL`, 1'b0, value driven on `dataout` when not transmitting

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request a transmission; sampled only in IDLE
- `abort`  in  1  synchronous cancel; returns to IDLE on next edge, no `done`
- `pattern`  in  PAT_W  bits to send; latched on accepted `start`
- `pat_len`  in  LEN_W  bits per repetition; latched on `start`
- `reps`  in  CNT_W  number of repetitions; latched on `start`
- `gap`  in  CNT_W  idle cycles between repetitions; latched on `start`
- `dataout`  out  1  serial bit to the identifier's `datain`
- `valid`  out  1  high while `dataout` carries a pattern bit
- `busy`  out  1  high in SEND and GAP
- `done`  out  1  one-cycle pulse on normal completion
- `state`  out  2  current FSM state, for debug

## Operation
- All outputs are registered. Reset values: `dataout`=IDLE_LVL, `valid`=0, `busy`=0, `done`=0, `state`=IDLE.
- FSM encoding: IDLE=2'd0, SEND=2'd1, GAP=2'd2, DONE=2'd3.
- Input clamping:
  - `pat_len`=0 or `pat_len`>PAT_W is treated as PAT_W.
  - `reps`=0 is treated as 1.
  - `gap`=0 gives back-to-back repetitions.
- Bit order: for effective length L, send `pattern[L-1]` down to `pattern[0]`. Bits above L-1 are ignored.
- Transitions:
  - IDLE→SEND on `start`=1. The configuration is latched, the bit index is set to L-1 and the rep counter is loaded.
  - SEND→SEND while bits remain in the current repetition.
  - SEND→GAP after the last bit, when more repetitions remain and the latched gap>0.
  - SEND→SEND after the last bit, when more repetitions remain and the latched gap=0. The next repetition's MSB follows immediately.
  - SEND→DONE after the last bit of the final repetition.
  - GAP→SEND after `gap` cycles in GAP.
  - DONE→IDLE unconditionally.
- `start` is ignored in SEND, GAP and DONE. Changes to the configuration inputs during a transmission have no effect.
- `abort`=1 in any non-IDLE state forces IDLE on the next edge with reset output values. `done` does not pulse. `abort` has priority over every other transition. `abort` together with `start` in IDLE: `start` is ignored.
- `rst` asserted mid-transmission clears outputs immediately, independent of the clock. The transmission is not resumed.
- Counters: the bit index is LEN_W wide and the rep and gap counters are CNT_W wide. All decrement and never wrap below zero.

## Timing
- `start` is sampled at edge k. After edge k: `state`=SEND, `dataout`=`pattern[L-1]`, `valid`=1, `busy`=1.
- Bit i of the stream (i=0 is the MSB) is on `dataout` during the cycle after edge k+i of its repetition.
- Per repetition:
  - SEND lasts exactly L cycles.
  - GAP lasts exactly `gap` cycles, with `valid`=0, `dataout`=IDLE_LVL and `busy`=1.
- Total busy cycles = reps·L + (reps−1)·gap.
- DONE lasts one cycle: `done`=1, `busy`=0, `valid`=0. A new `start` is accepted earliest in the IDLE cycle that follows.
- Latency from `start` to first bit: 1 cycle.

## Test plan
- Basic: `pattern`=8'b1011_0110, `pat_len`=8, `reps`=1, `gap`=0, one-cycle `start` → `dataout` shows 1,0,1,1,0,1,1,0 on 8 consecutive cycles with `valid`=1. `done` pulses on the 9th cycle after the start edge; `busy` is high for exactly 8 cycles.
- Short pattern with repeats: `pattern`=8'hxB, `pat_len`=4, `reps`=3, `gap`=2 → stream 1011 00 1011 00 1011 with `valid` low in the gaps. Busy cycles = 16. The identifier `hit` asserts at the expected positions for its configured sequence.
- Clamping: `pat_len`=0, `reps`=0 → a single 8-bit transmission, identical to the Basic case.
- Back-to-back: `pattern`=4'b0110, `pat_len`=4, `reps`=2, `gap`=0 → 01100110 with `valid` continuously high for 8 cycles. A `start` pulse during busy is ignored.
- Abort: `abort` high in the 3rd SEND cycle → IDLE on the next edge, `dataout`=IDLE_LVL, `valid`=0, and `done` never asserts. A fresh `start` afterwards transmits from the MSB.
- Async reset: `rst` raised mid-GAP, between clock edges → all outputs take reset values before the next edge. After release, `state` is IDLE and the bench restarts cleanly.
